// File: rtl/alu_ctrl_fsm.sv
// Multicycle control FSM for the reduced RISC-V core: fetch, decode, ALU control, memory and writeback.
// Define CTRL_PERF_CNT_EN to build the retired-instruction counter on instr_count.
module alu_ctrl_fsm #(
    parameter int WIDTH           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instr,
    input  logic             instr_valid,
    output logic             instr_req,
    input  logic             EQ,
    output logic [2:0]       ALUctrl,
    output logic             ALUsrc,
    output logic [1:0]       ImmSrc,
    output logic             MemRead,
    output logic             MemWrite,
    input  logic             mem_ready,
    output logic             ResultSrc,
    output logic             RegWrite,
    output logic             PCwrite,
    output logic             PCsrc,
    output logic             illegal,
    output logic [31:0]      instr_count
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {C_ILL, C_ADDI, C_ADD, C_BEQ, C_BNE, C_LW, C_SW} cls_t;

    function automatic cls_t classify(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        cls_t c;
        c = C_ILL;
        case (op)
            7'b0010011: if (f3 == 3'b000) c = C_ADDI;
            7'b0110011: if (f3 == 3'b000 && f7 == 7'b0000000) c = C_ADD;
            7'b1100011: if (f3 == 3'b000) c = C_BEQ; else if (f3 == 3'b001) c = C_BNE;
            7'b0000011: if (f3 == 3'b010) c = C_LW;
            7'b0100011: if (f3 == 3'b010) c = C_SW;
            default: c = C_ILL;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] alu_ctrl_of(input cls_t c);
        return (c == C_BEQ || c == C_BNE) ? 3'b001 : 3'b000;
    endfunction

    function automatic logic alu_src_of(input cls_t c);
        return (c == C_ADDI || c == C_LW || c == C_SW);
    endfunction

    function automatic logic [1:0] imm_src_of(input cls_t c);
        if (c == C_BEQ || c == C_BNE) return 2'b01;
        if (c == C_SW) return 2'b10;
        return 2'b00;
    endfunction

    state_t           state_q;
    logic [WIDTH-1:0] instr_q;
    logic             instr_req_q, illegal_q, alu_src_q, mem_read_q, mem_write_q;
    logic             reg_write_q, result_src_q;
    logic [2:0]       alu_ctrl_q;
    logic [1:0]       imm_src_q;

    cls_t cls, cls_in;
    logic is_br, is_mem, rd_nz;
    logic unused_fields;

    assign cls           = classify(instr_q[6:0], instr_q[14:12], instr_q[31:25]);
    assign cls_in        = classify(instr[6:0], instr[14:12], instr[31:25]);
    assign is_br         = (cls == C_BEQ) || (cls == C_BNE);
    assign is_mem        = (cls == C_LW) || (cls == C_SW);
    assign rd_nz         = (instr_q[11:7] != 5'd0);
    assign unused_fields = ^instr_q[24:15];

    // ALU operand controls are loaded with the instruction so they are stable from DECODE onwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            instr_q      <= '0;
            instr_req_q  <= 1'b1;
            illegal_q    <= 1'b0;
            alu_ctrl_q   <= 3'b000;
            alu_src_q    <= 1'b0;
            imm_src_q    <= 2'b00;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: if (instr_valid) begin
                    state_q     <= S_DECODE;
                    instr_q     <= instr;
                    instr_req_q <= 1'b0;
                    alu_ctrl_q  <= alu_ctrl_of(cls_in);
                    alu_src_q   <= alu_src_of(cls_in);
                    imm_src_q   <= imm_src_of(cls_in);
                end
                S_DECODE: if (cls == C_ILL) begin
                    illegal_q <= 1'b1;
                    if (HALT_ON_ILLEGAL) begin
                        state_q <= S_HALT;
                    end else begin
                        state_q     <= S_FETCH;
                        instr_req_q <= 1'b1;
                    end
                end else begin
                    state_q <= S_EXEC;
                end
                S_EXEC: if (is_br) begin
                    state_q     <= S_FETCH;
                    instr_req_q <= 1'b1;
                    alu_ctrl_q  <= 3'b000;
                    alu_src_q   <= 1'b0;
                    imm_src_q   <= 2'b00;
                end else if (is_mem) begin
                    state_q     <= S_MEM;
                    mem_read_q  <= (cls == C_LW);
                    mem_write_q <= (cls == C_SW);
                end else begin
                    state_q      <= S_WB;
                    reg_write_q  <= rd_nz;
                    result_src_q <= 1'b0;
                end
                S_MEM: if (mem_ready) begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    if (cls == C_LW) begin
                        state_q      <= S_WB;
                        reg_write_q  <= rd_nz;
                        result_src_q <= 1'b1;
                    end else begin
                        state_q     <= S_FETCH;
                        instr_req_q <= 1'b1;
                        alu_ctrl_q  <= 3'b000;
                        alu_src_q   <= 1'b0;
                        imm_src_q   <= 2'b00;
                    end
                end
                S_WB: begin
                    state_q      <= S_FETCH;
                    instr_req_q  <= 1'b1;
                    reg_write_q  <= 1'b0;
                    result_src_q <= 1'b0;
                    alu_ctrl_q   <= 3'b000;
                    alu_src_q    <= 1'b0;
                    imm_src_q    <= 2'b00;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // PC strobe depends on EQ and mem_ready in the same cycle, so it stays combinational.
    always_comb begin
        PCwrite = 1'b0;
        PCsrc   = 1'b0;
        case (state_q)
            S_DECODE: PCwrite = (cls == C_ILL) && !HALT_ON_ILLEGAL;
            S_EXEC: if (is_br) begin
                PCwrite = 1'b1;
                PCsrc   = (cls == C_BEQ) ? EQ : ~EQ;
            end
            S_MEM:  PCwrite = mem_ready && (cls == C_SW);
            S_WB:   PCwrite = 1'b1;
            default: PCwrite = 1'b0;
        endcase
    end

    assign instr_req = instr_req_q;
    assign illegal   = illegal_q;
    assign ALUctrl   = alu_ctrl_q;
    assign ALUsrc    = alu_src_q;
    assign ImmSrc    = imm_src_q;
    assign MemRead   = mem_read_q;
    assign MemWrite  = mem_write_q;
    assign RegWrite  = reg_write_q;
    assign ResultSrc = result_src_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instr_count_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          instr_count_q <= '0;
        else if (PCwrite) instr_count_q <= instr_count_q + 32'd1;
    end
    assign instr_count = instr_count_q;
`else
    assign instr_count = '0;
`endif
endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Scoreboard bench for alu_ctrl_fsm: per-cycle expected outputs are queued with their stimulus.
module tb_alu_ctrl_fsm;
    typedef logic [13:0] o_t; // {req, ALUctrl[2:0], ALUsrc, ImmSrc[1:0], MemRead, MemWrite, ResultSrc, RegWrite, PCwrite, PCsrc, illegal}
    typedef struct {
        logic iv, eq, mrdy;
        o_t   x, m;
    } ent_t;

    localparam o_t ALL  = 14'h3FFF;
    localparam o_t STRB = 14'b1_000_0_00_1101101;
    localparam o_t IDLE = 14'b1_000_0_00_0000000;
`ifdef CTRL_PERF_CNT_EN
    localparam logic [31:0] EXP_CNT = 32'd3;
`else
    localparam logic [31:0] EXP_CNT = 32'd0;
`endif

    logic        clk, rst, instr_valid, instr_req, EQ, ALUsrc, MemRead, MemWrite, mem_ready;
    logic        ResultSrc, RegWrite, PCwrite, PCsrc, illegal;
    logic [31:0] instr, instr_count;
    logic [2:0]  ALUctrl;
    logic [1:0]  ImmSrc;
    int          checks = 0, errors = 0;
    ent_t        sb[$];

    alu_ctrl_fsm dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_req(instr_req),
        .EQ(EQ), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc), .MemRead(MemRead),
        .MemWrite(MemWrite), .mem_ready(mem_ready), .ResultSrc(ResultSrc), .RegWrite(RegWrite),
        .PCwrite(PCwrite), .PCsrc(PCsrc), .illegal(illegal), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic o_t o(input logic req, input logic [2:0] ac, input logic src, input logic [1:0] imm,
                             input logic mr, mw, rs, rw, pcw, pcs, ill);
        return {req, ac, src, imm, mr, mw, rs, rw, pcw, pcs, ill};
    endfunction

    function automatic o_t outs();
        return {instr_req, ALUctrl, ALUsrc, ImmSrc, MemRead, MemWrite, ResultSrc, RegWrite, PCwrite, PCsrc, illegal};
    endfunction

    function automatic void push(input logic iv, eq, mrdy, input o_t x, m);
        ent_t e;
        e.iv = iv; e.eq = eq; e.mrdy = mrdy; e.x = x; e.m = m;
        sb.push_back(e);
    endfunction

    task automatic test_reset();
        rst = 1'b1; instr = '0; instr_valid = 1'b0; EQ = 1'b0; mem_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (outs() !== IDLE) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs(), IDLE); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (outs() !== IDLE) begin errors++; $display("FAIL reset_idle got=%b exp=%b", outs(), IDLE); end
    endtask

    task automatic test_addi();
        ent_t e; int n = 0;
        instr = 32'h00500093;
        push(1, 0, 0, IDLE, ALL);
        push(1, 0, 0, o(0, 3'd0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0), ALL);
        push(1, 0, 0, o(0, 3'd0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0), ALL);
        push(1, 0, 0, o(0, 3'd0, 1, 2'd0, 0, 0, 0, 1, 1, 0, 0), ALL);
        push(0, 0, 0, IDLE, STRB);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); instr_valid = e.iv; EQ = e.eq; mem_ready = e.mrdy; #1;
            checks++;
            if ((outs() & e.m) !== (e.x & e.m)) begin errors++; $display("FAIL addi cyc%0d got=%b exp=%b", n, outs(), e.x); end
            n++;
        end
    endtask

    task automatic test_branch();
        ent_t e; int n;
        instr = 32'h00209463;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            push(1, k[0], 0, IDLE, ALL);
            push(0, k[0], 0, o(0, 3'd1, 0, 2'd1, 0, 0, 0, 0, 0, 0, 0), ALL);
            push(0, k[0], 0, o(0, 3'd1, 0, 2'd1, 0, 0, 0, 0, 1, ~k[0], 0), ALL);
            push(0, k[0], 0, IDLE, STRB);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                @(negedge clk); instr_valid = e.iv; EQ = e.eq; mem_ready = e.mrdy; #1;
                checks++;
                if ((outs() & e.m) !== (e.x & e.m)) begin errors++; $display("FAIL bne_eq%0d cyc%0d got=%b exp=%b", k, n, outs(), e.x); end
                n++;
            end
        end
    endtask

    task automatic test_lw();
        ent_t e; int n = 0;
        instr = 32'h0000A283;
        push(1, 0, 1, IDLE, ALL);
        push(0, 0, 1, o(0, 3'd0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0), ALL);
        push(0, 0, 1, o(0, 3'd0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0), ALL);
        push(0, 0, 0, o(0, 3'd0, 1, 2'd0, 1, 0, 0, 0, 0, 0, 0), ALL);
        push(0, 0, 0, o(0, 3'd0, 1, 2'd0, 1, 0, 0, 0, 0, 0, 0), ALL);
        push(0, 0, 1, o(0, 3'd0, 1, 2'd0, 1, 0, 0, 0, 0, 0, 0), ALL);
        push(0, 0, 0, o(0, 3'd0, 1, 2'd0, 0, 0, 1, 1, 1, 0, 0), ALL);
        push(0, 0, 0, IDLE, STRB);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); instr_valid = e.iv; EQ = e.eq; mem_ready = e.mrdy; #1;
            checks++;
            if ((outs() & e.m) !== (e.x & e.m)) begin errors++; $display("FAIL lw cyc%0d got=%b exp=%b", n, outs(), e.x); end
            n++;
        end
    endtask

    task automatic test_add_x0();
        ent_t e; int n = 0;
        instr = 32'h00208033;
        push(1, 0, 0, IDLE, ALL);
        push(0, 0, 0, o(0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0), ALL);
        push(0, 0, 0, o(0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0), ALL);
        push(0, 0, 0, o(0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 0), ALL);
        push(0, 0, 0, IDLE, STRB);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); instr_valid = e.iv; EQ = e.eq; mem_ready = e.mrdy; #1;
            checks++;
            if ((outs() & e.m) !== (e.x & e.m)) begin errors++; $display("FAIL add_x0 cyc%0d got=%b exp=%b", n, outs(), e.x); end
            n++;
        end
    endtask

    task automatic test_sw();
        ent_t e; int n = 0;
        instr = 32'h0020A023;
        push(1, 0, 0, IDLE, ALL);
        push(0, 0, 0, o(0, 3'd0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0), ALL);
        push(0, 0, 0, o(0, 3'd0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0), ALL);
        push(0, 0, 1, o(0, 3'd0, 1, 2'd2, 0, 1, 0, 0, 1, 0, 0), ALL);
        push(0, 0, 0, IDLE, STRB);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); instr_valid = e.iv; EQ = e.eq; mem_ready = e.mrdy; #1;
            checks++;
            if ((outs() & e.m) !== (e.x & e.m)) begin errors++; $display("FAIL sw cyc%0d got=%b exp=%b", n, outs(), e.x); end
            n++;
        end
    endtask

    task automatic test_reset_mid_sw();
        ent_t e; int n = 0;
        instr = 32'h0020A023;
        push(1, 0, 0, IDLE, ALL);
        push(0, 0, 0, o(0, 3'd0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0), ALL);
        push(0, 0, 0, o(0, 3'd0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0), ALL);
        push(0, 0, 0, o(0, 3'd0, 1, 2'd2, 0, 1, 0, 0, 0, 0, 0), ALL);
        push(0, 0, 0, o(0, 3'd0, 1, 2'd2, 0, 1, 0, 0, 0, 0, 0), ALL);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); instr_valid = e.iv; EQ = e.eq; mem_ready = e.mrdy; #1;
            checks++;
            if ((outs() & e.m) !== (e.x & e.m)) begin errors++; $display("FAIL sw_abort cyc%0d got=%b exp=%b", n, outs(), e.x); end
            n++;
        end
        rst = 1'b1; #1;
        checks++; if (outs() !== IDLE) begin errors++; $display("FAIL sw_abort_async got=%b exp=%b", outs(), IDLE); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL sw_abort_count got=%0d exp=0", instr_count); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (outs() !== IDLE) begin errors++; $display("FAIL sw_abort_fetch got=%b exp=%b", outs(), IDLE); end
    endtask

    task automatic test_illegal();
        ent_t e; int n = 0;
        instr = 32'hFFFFFFFF;
        push(1, 0, 0, IDLE, ALL);
        push(1, 0, 0, 14'h0000, STRB);
        for (int k = 0; k < 4; k++) push(1, 0, 1, 14'h0001, STRB);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); instr_valid = e.iv; EQ = e.eq; mem_ready = e.mrdy; #1;
            checks++;
            if ((outs() & e.m) !== (e.x & e.m)) begin errors++; $display("FAIL illegal cyc%0d got=%b exp=%b", n, outs(), e.x); end
            n++;
        end
        instr_valid = 1'b0; mem_ready = 1'b0;
        rst = 1'b1; #1;
        checks++; if (outs() !== IDLE) begin errors++; $display("FAIL halt_reset got=%b exp=%b", outs(), IDLE); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        ent_t e; int n = 0;
        instr = 32'h00500093;
        for (int k = 0; k < 3; k++) begin
            push(1, 0, 0, IDLE, (k == 0) ? ALL : STRB);
            push(1, 0, 0, o(0, 3'd0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0), ALL);
            push(1, 0, 0, o(0, 3'd0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0), ALL);
            push(1, 0, 0, o(0, 3'd0, 1, 2'd0, 0, 0, 0, 1, 1, 0, 0), ALL);
        end
        push(0, 0, 0, IDLE, STRB);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            @(negedge clk); instr_valid = e.iv; EQ = e.eq; mem_ready = e.mrdy; #1;
            checks++;
            if ((outs() & e.m) !== (e.x & e.m)) begin errors++; $display("FAIL b2b cyc%0d got=%b exp=%b", n, outs(), e.x); end
            n++;
        end
        checks++;
        if (instr_count !== EXP_CNT) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", instr_count, EXP_CNT); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_addi();
        test_branch();
        test_lw();
        test_add_x0();
        test_sw();
        test_reset_mid_sw();
        test_illegal();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
